// File: rtl/decoder_arb_pkg.sv
// Shared types, sizes and the round-robin search for the four-way decoder arbiter.
package decoder_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Result of a priority search: whether anyone was found and who.
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // Rotate the request vector so ptr lands at bit 0, then find the first set bit.
  // The lowest rotated position wins, so the search order is ptr, ptr+1, ptr+2, ptr+3.
  function automatic pick_t rr_pick(input req_t req, input idx_t ptr);
    logic [2*NUM_REQ-1:0] dbl;
    req_t                 rot;
    pick_t                pick;
    dbl  = {req, req};
    rot  = dbl[{1'b0, ptr} +: NUM_REQ];
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick.found = 1'b1;
        pick.idx   = ptr + IDX_W'(k);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder2to4.sv
// Index-to-one-hot decoder with enable; all-zero output when disabled.
module decoder2to4
  import decoder_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_c_o
);

  // Exactly one bit set when enabled, so the decoded select can never be multi-hot.
  always_comb begin
    onehot_c_o = '0;
    if (en_i) begin
      onehot_c_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Four-way round-robin arbiter with optional hold-limit preemption.
// Drives the registered owner index and its registered one-hot decode.
module decoder_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  idx_t               ptr_q, ptr_d;
  idx_t               idx_q, idx_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  pick_t pick;
  logic  owner_req;
  logic  others_wait;
  logic  preempt;
  logic  release_c;

  // Arbitration terms derived from the current owner and live requests.
  assign pick        = rr_pick(req, ptr_q);
  assign owner_req   = req[idx_q];
  assign others_wait = (req & ~gnt_q) != '0;
  assign preempt     = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) && others_wait;
  assign release_c   = !owner_req || preempt;

  // Next-state: IDLE picks an owner; GRANT counts hold time and releases once.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = GRANT;
          idx_d   = pick.idx;
          hold_d  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          idx_d   = '0;
          hold_d  = '0;
        end else if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Grant is valid exactly while the next state is GRANT.
  assign valid_d = (state_d == GRANT);

  // Decode the next owner so gnt is registered alongside gnt_idx and never disagrees with it.
  decoder2to4 u_dec (
    .idx_i      (idx_d),
    .en_i       (valid_d),
    .onehot_c_o (gnt_d)
  );

  // State and output registers; reset clears every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

  // The datapath select must never be multi-hot.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

  // Valid flag and decoded grant always agree.
  a_valid_match : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (gnt_q != '0));

  // Index returns to zero whenever nobody owns the resource.
  a_idle_index : assert property (@(posedge clk) disable iff (!rst_n) valid_q || (idx_q == '0));

endmodule

// File: tb/tb_decoder_arbiter.sv
// Scoreboard bench for decoder_arbiter: a hold-limited instance (MAX_HOLD=4) checked
// cycle by cycle against a behavioural model, plus a no-preemption instance (MAX_HOLD=0).
module tb_decoder_arbiter;
  import decoder_arb_pkg::*;

  localparam int unsigned HOLD_A = 4;
  // Three other owners at HOLD_A cycles plus their idle gaps, plus the idle cycle
  // in which a waiting requester is first sampled.
  localparam int unsigned WAIT_LIMIT = 3 * (HOLD_A + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_valid_a, gnt_valid_b;

  always #5 clk = ~clk;

  decoder_arbiter #(.MAX_HOLD(HOLD_A)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_idx   (gnt_idx_a),
    .gnt_valid (gnt_valid_a)
  );

  decoder_arbiter #(.MAX_HOLD(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_idx   (gnt_idx_b),
    .gnt_valid (gnt_valid_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model of the arbiter with MAX_HOLD=HOLD_A.
  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } exp_t;

  typedef struct {
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       busy;
    int         hold;
  } mdl_t;

  localparam mdl_t MDL_RST = '{ptr: 2'd0, idx: 2'd0, busy: 1'b0, hold: 0};

  exp_t exp_q[$];
  mdl_t mdl;

  function automatic mdl_t mdl_next(input mdl_t s, input logic [3:0] r);
    mdl_t       n;
    logic [1:0] c;
    logic       hit;
    logic [3:0] own;
    n   = s;
    hit = 1'b0;
    own = 4'b0001 << s.idx;
    if (!s.busy) begin
      for (int k = 0; k < 4; k++) begin
        c = s.ptr + 2'(k);
        if (!hit && r[c]) begin
          hit    = 1'b1;
          n.busy = 1'b1;
          n.idx  = c;
          n.hold = 1;
        end
      end
    end else begin
      if (!r[s.idx] || (s.hold == int'(HOLD_A) && (r & ~own) != 4'b0000)) begin
        n.busy = 1'b0;
        n.ptr  = s.idx + 2'd1;
        n.idx  = 2'd0;
        n.hold = 0;
      end else if (s.hold < int'(HOLD_A)) begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(input mdl_t s);
    exp_t e;
    e.valid = s.busy;
    e.idx   = s.busy ? s.idx : 2'd0;
    e.gnt   = s.busy ? (4'b0001 << s.idx) : 4'b0000;
    return e;
  endfunction

  function automatic logic [3:0] dec4(input logic [1:0] i, input logic en);
    logic [3:0] v;
    v = 4'b0000;
    if (en) v[i] = 1'b1;
    return v;
  endfunction

  // Predict the outputs each edge and queue them for comparison half a cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl <= MDL_RST;
      exp_q.delete();
    end else begin
      mdl <= mdl_next(mdl, req_a);
      exp_q.push_back(mk_exp(mdl_next(mdl, req_a)));
    end
  end

  int wait_a[4];

  // Pop predictions, check structural invariants on both instances, and bound waiting.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_eq("sb_gnt", 32'(gnt_a), 32'(exp_q[0].gnt));
      check_eq("sb_idx", 32'(gnt_idx_a), 32'(exp_q[0].idx));
      check_eq("sb_valid", 32'(gnt_valid_a), 32'(exp_q[0].valid));
      void'(exp_q.pop_front());
    end
    check_eq("onehot_a", 32'($countones(gnt_a) <= 1), 32'd1);
    check_eq("decode_a", 32'(gnt_a), 32'(dec4(gnt_idx_a, gnt_valid_a)));
    check_eq("idle_idx_a", 32'(!gnt_valid_a && gnt_idx_a != 2'd0), 32'd0);
    check_eq("onehot_b", 32'($countones(gnt_b) <= 1), 32'd1);
    check_eq("decode_b", 32'(gnt_b), 32'(dec4(gnt_idx_b, gnt_valid_b)));
    check_eq("idle_idx_b", 32'(!gnt_valid_b && gnt_idx_b != 2'd0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("wait_bound", 32'(wait_a[i] > int'(WAIT_LIMIT)), 32'd0);
      wait_a[i] <= (rst_n && req_a[i] && !gnt_a[i]) ? wait_a[i] + 1 : 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit sel_b, input logic [3:0] g,
                            input logic [1:0] i, input logic v);
    @(negedge clk);
    if (sel_b) begin
      check_eq({tag, "_gnt"}, 32'(gnt_b), 32'(g));
      check_eq({tag, "_idx"}, 32'(gnt_idx_b), 32'(i));
      check_eq({tag, "_valid"}, 32'(gnt_valid_b), 32'(v));
    end else begin
      check_eq({tag, "_gnt"}, 32'(gnt_a), 32'(g));
      check_eq({tag, "_idx"}, 32'(gnt_idx_a), 32'(i));
      check_eq({tag, "_valid"}, 32'(gnt_valid_a), 32'(v));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    for (int i = 0; i < 4; i++) wait_a[i] = 0;

    tick(2);
    expect_out("reset_a", 1'b0, 4'b0000, 2'd0, 1'b0);
    expect_out("reset_b", 1'b1, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // Single requester: one-edge grant, one-edge release, then ptr=3 is visible.
    req_a = 4'b0100;
    tick(1);
    expect_out("t1_grant", 1'b0, 4'b0100, 2'd2, 1'b1);
    req_a = 4'b0000;
    tick(1);
    expect_out("t1_release", 1'b0, 4'b0000, 2'd0, 1'b0);
    req_a = 4'b1100;
    tick(1);
    expect_out("t1_ptr3", 1'b0, 4'b1000, 2'd3, 1'b1);
    req_a = 4'b0000;
    tick(1);
    expect_out("t1_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Wrap-around search from ptr=2 with requesters 0 and 3.
    req_a = 4'b0010;
    tick(1);
    expect_out("t3_own1", 1'b0, 4'b0010, 2'd1, 1'b1);
    req_a = 4'b1001;
    tick(1);
    expect_out("t3_gap1", 1'b0, 4'b0000, 2'd0, 1'b0);
    tick(1);
    expect_out("t3_wrap3", 1'b0, 4'b1000, 2'd3, 1'b1);
    req_a = 4'b0001;
    tick(1);
    expect_out("t3_gap2", 1'b0, 4'b0000, 2'd0, 1'b0);
    tick(1);
    expect_out("t3_wrap0", 1'b0, 4'b0001, 2'd0, 1'b1);
    req_a = 4'b0000;
    tick(1);

    // Bring ptr back to 0, then full contention: 0,1,2,3,0 each for HOLD_A cycles.
    req_a = 4'b1000;
    tick(1);
    req_a = 4'b0000;
    tick(1);
    req_a = 4'b1111;
    tick(1);
    for (int n = 0; n < 5; n++) begin
      repeat (HOLD_A) begin
        expect_out("t2_hold", 1'b0, 4'(4'b0001 << order[n]), 2'(order[n]), 1'b1);
        tick(1);
      end
      expect_out("t2_gap", 1'b0, 4'b0000, 2'd0, 1'b0);
      tick(1);
    end
    req_a = 4'b0000;
    tick(1);
    expect_out("t2_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset in the middle of owner 2's grant.
    req_a = 4'b0100;
    tick(1);
    expect_out("t5_own2", 1'b0, 4'b0100, 2'd2, 1'b1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_gnt", 32'(gnt_a), 32'd0);
    check_eq("t5_async_idx", 32'(gnt_idx_a), 32'd0);
    check_eq("t5_async_valid", 32'(gnt_valid_a), 32'd0);
    tick(3);
    expect_out("t5_in_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    expect_out("t5_resume", 1'b0, 4'b0100, 2'd2, 1'b1);
    req_a = 4'b0000;
    tick(1);

    // No preemption: owner 0 keeps the grant while owner 1 waits.
    req_b = 4'b0011;
    tick(1);
    repeat (50) begin
      expect_out("t4_hold", 1'b1, 4'b0001, 2'd0, 1'b1);
      tick(1);
    end
    req_b = 4'b0010;
    tick(1);
    expect_out("t4_gap", 1'b1, 4'b0000, 2'd0, 1'b0);
    tick(1);
    expect_out("t4_next", 1'b1, 4'b0010, 2'd1, 1'b1);
    req_b = 4'b0000;
    tick(1);

    // Random traffic: requesters hold until granted, owners drop at random.
    repeat (10000) begin
      tick(1);
      for (int i = 0; i < 4; i++) begin
        if (req_a[i]) begin
          if (gnt_a[i] && $urandom_range(3) == 0) req_a[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_a[i] = 1'b1;
        end
      end
    end
    req_a = 4'b0000;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
